// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: opcodes, states,
// datapath mux selects and the packed strobe bundle.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_WB_ALU  = 4'd4,
        S_MEM_RD  = 4'd5,
        S_WB_MEM  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_HALTED  = 4'd10,
        S_ILLEGAL = 4'd11
    } state_e;

    localparam logic [1:0] OP_CLASS_R = 2'b00;
    localparam logic [1:0] OP_CLASS_I = 2'b01;
    localparam logic [5:0] OP_LW      = 6'b100000;
    localparam logic [5:0] OP_SW      = 6'b100001;
    localparam logic [5:0] OP_BZ      = 6'b100010;
    localparam logic [5:0] OP_BNZ     = 6'b100011;
    localparam logic [5:0] OP_J       = 6'b100100;
    localparam logic [5:0] OP_HALT    = 6'b111111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_ONE     = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] BR_ZERO      = 2'b01;
    localparam logic [1:0] BR_NZERO     = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'h0;

    typedef struct packed {
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] branch;
        logic       reg_src;
        logic       reg_write;
        logic       sn;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic state_e decode_next(input logic [5:0] op);
        if (op[5:4] == OP_CLASS_R) return S_EXEC_R;
        if (op[5:4] == OP_CLASS_I) return S_EXEC_I;
        case (op)
            OP_LW:            return S_MEM_RD;
            OP_SW:            return S_MEM_WR;
            OP_BZ, OP_BNZ:    return S_BRANCH;
            OP_J:             return S_JUMP;
            OP_HALT:          return S_HALTED;
            default:          return S_ILLEGAL;
        endcase
    endfunction

    // Stores and branches compare/store the R2 operand through read port 1.
    function automatic logic sn_sel(input logic [5:0] op);
        return !((op == OP_SW) || (op == OP_BZ) || (op == OP_BNZ));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Moore output map: (state, opcode) to datapath strobes, before reset gating.
module ctrl_out_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [3:0] ADD_OP = ALU_ADD
) (
    input  state_e     state,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl    = '0;
        ctrl.sn = (state != S_FETCH) && (state != S_HALTED) && (state != S_ILLEGAL)
                  && sn_sel(opcode);
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ADD_OP;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ADD_OP;
            end
            S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
                // Writeback keeps the execute controls so ALUOut stays valid.
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = (opcode[5:4] == OP_CLASS_R) ? SRCB_B : SRCB_IMM;
                ctrl.alu_op    = opcode[3:0];
                ctrl.reg_write = (state == S_WB_ALU);
            end
            S_WB_MEM: begin
                ctrl.reg_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_MEM_WR: ctrl.mem_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ADD_OP;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = (opcode == OP_BNZ) ? BR_NZERO : BR_ZERO;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            S_HALTED: ctrl.halted = 1'b1;
            S_ILLEGAL: begin
                ctrl.halted  = 1'b1;
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath sequencer: state register, next-state logic and
// retired-instruction counter; strobes come from ctrl_out_decode.
module multicycle_ctrl #(
    parameter int         CNT_W   = 16,
    parameter logic [3:0] ALU_ADD = 4'h0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Opcode,
    output logic             MemWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic [1:0]       Branch,
    output logic             RegSrc,
    output logic             RegWrite,
    output logic             SN,
    output logic             Halted,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);
    import multicycle_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_raw, ctrl;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:                     state_d = S_DECODE;
            S_DECODE:                    state_d = decode_next(Opcode);
            S_EXEC_R, S_EXEC_I:          state_d = S_WB_ALU;
            S_MEM_RD:                    state_d = S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_MEM_WR,
            S_BRANCH, S_JUMP:            state_d = S_FETCH;
            S_HALTED, S_ILLEGAL:         state_d = state_q;
            default:                     state_d = S_FETCH;
        endcase
    end

    // HALT counts as retired; an illegal opcode does not.
    always_comb begin
        cnt_d = cnt_q;
        if (((state_d == S_FETCH) && (state_q != S_FETCH)) ||
            ((state_d == S_HALTED) && (state_q != S_HALTED)))
            cnt_d = cnt_q + CNT_W'(1);
    end

    ctrl_out_decode #(
        .ADD_OP (ALU_ADD)
    ) u_out_decode (
        .state  (state_q),
        .opcode (Opcode),
        .ctrl   (ctrl_raw)
    );

    // Reset silences every strobe immediately, without waiting for a clock.
    assign ctrl = Reset ? ctrl_raw : '0;

    assign MemWrite   = ctrl.mem_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign IRWrite    = ctrl.ir_write;
    assign PCWrite    = ctrl.pc_write;
    assign PCSrc      = ctrl.pc_src;
    assign Branch     = ctrl.branch;
    assign RegSrc     = ctrl.reg_src;
    assign RegWrite   = ctrl.reg_write;
    assign SN         = ctrl.sn;
    assign Halted     = ctrl.halted;
    assign Illegal    = ctrl.illegal;
    assign State      = state_q;
    assign InstrCount = cnt_q;

endmodule
